// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/result bundle between the execute stage and muldiv_unit.
// The execute stage drives the master side; the unit is the slave.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [1:0]       i_op;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_hi_we;
   logic             i_lo_we;
   logic [WIDTH-1:0] i_wdata;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;

   modport master (
      output i_start, i_op, i_a, i_b,
      output i_hi_we, i_lo_we, i_wdata,
      input  o_busy, o_done, o_hi, o_lo
   );

   modport slave (
      input  i_start, i_op, i_a, i_b,
      input  i_hi_we, i_lo_we, i_wdata,
      output o_busy, o_done, o_hi, o_lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO ownership.
// MULDIV_SIGNED_EN enables signed MULT/DIV; otherwise all ops are unsigned.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic         i_clk,
   input logic         i_rst_n,
   muldiv_unit_if.slave bus
);

`ifdef MULDIV_SIGNED_EN
   localparam logic SGN_EN = 1'b1;
`else
   localparam logic SGN_EN = 1'b0;
`endif

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [1:0]       op;
   logic [WIDTH-1:0] a_raw;
   logic [WIDTH-1:0] b_mag;
   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             done_q;

   logic             sgn_in;
   logic             sgn;
   logic [WIDTH-1:0] a_mag_in;
   logic [WIDTH-1:0] b_mag_in;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_diff;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;

   // Operand magnitudes at issue and one shift-add / restoring step.
   always_comb begin
      sgn_in   = SGN_EN & bus.i_op[0];
      sgn      = SGN_EN & op[0];
      a_mag_in = (sgn_in && bus.i_a[WIDTH-1]) ? -bus.i_a : bus.i_a;
      b_mag_in = (sgn_in && bus.i_b[WIDTH-1]) ? -bus.i_b : bus.i_b;
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
      div_sh   = {acc_hi, acc_lo[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_mag};
      prod_neg = -{acc_hi, acc_lo};
   end

   // Final HI/LO value: special divide cases, then sign correction.
   always_comb begin
      fix_hi = acc_hi;
      fix_lo = acc_lo;
      if (op[1]) begin
         if (b_mag == '0) begin
            fix_hi = a_raw;
            fix_lo = '1;
         end else if (sgn && a_raw == MIN && neg_b && b_mag == ONE) begin
            fix_hi = '0;
            fix_lo = MIN;
         end else begin
            if (neg_a ^ neg_b) fix_lo = -acc_lo;
            if (neg_a)         fix_hi = -acc_hi;
         end
      end else if (neg_a ^ neg_b) begin
         {fix_hi, fix_lo} = prod_neg;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.i_start) state_nx = RUN;
         RUN:     if (cnt == CW'(WIDTH-1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, HI/LO write-back and MTHI/MTLO.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt    <= '0;
         op     <= '0;
         a_raw  <= '0;
         b_mag  <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         acc_hi <= '0;
         acc_lo <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.i_hi_we) hi_q <= bus.i_wdata;
               if (bus.i_lo_we) lo_q <= bus.i_wdata;
               if (bus.i_start) begin
                  op     <= bus.i_op;
                  a_raw  <= bus.i_a;
                  b_mag  <= b_mag_in;
                  neg_a  <= sgn_in & bus.i_a[WIDTH-1];
                  neg_b  <= sgn_in & bus.i_b[WIDTH-1];
                  acc_hi <= '0;
                  acc_lo <= a_mag_in;
                  cnt    <= '0;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (op[1]) begin
                  if (!div_diff[WIDTH]) acc_hi <= div_diff[WIDTH-1:0];
                  else                  acc_hi <= div_sh[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
               end else begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               end
            end
            FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_busy = (state != IDLE);
   assign bus.o_done = done_q;
   assign bus.o_hi   = hi_q;
   assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Expected HI/LO come from a 64-bit arithmetic model at issue time.
module tb_muldiv_unit;

`ifdef MULDIV_SIGNED_EN
   localparam bit SGN_EN = 1'b1;
`else
   localparam bit SGN_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [63:0] sb[$];

   muldiv_unit_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      bit     s;
      longint sa, sb_, q, m;
      s  = SGN_EN && op[0];
      sa = s ? longint'({{32{a[31]}}, a}) : longint'({32'b0, a});
      sb_ = s ? longint'({{32{b[31]}}, b}) : longint'({32'b0, b});
      if (!op[1]) return 64'(sa * sb_);
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return {32'h0, 32'h8000_0000};
      q = sa / sb_;
      m = sa % sb_;
      return {m[31:0], q[31:0]};
   endfunction

   // Result monitor: every done pulse must match the oldest issued op.
   always @(negedge clk) begin
      if (rst_n && bus.o_done) begin
         if (sb.size() == 0) check("spurious_done", 1, 0);
         else check("result", {bus.o_hi, bus.o_lo}, sb.pop_front());
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push);
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      if (push) sb.push_back(model(op, a, b));
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.o_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", bus.o_busy, 0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] lo0;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.i_start = 1'b0;
      bus.i_op    = '0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      bus.i_hi_we = 1'b0;
      bus.i_lo_we = 1'b0;
      bus.i_wdata = '0;
      #1;
      check("rst_busy", bus.o_busy, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_hi", bus.o_hi, 0);
      check("rst_lo", bus.o_lo, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      bus.i_hi_we = 1'b1;
      bus.i_wdata = 32'hABCD;
      @(negedge clk);
      bus.i_hi_we = 1'b0;
      check("mthi_idle", bus.o_hi, 32'hABCD);
      bus.i_lo_we = 1'b1;
      bus.i_wdata = 32'h5555;
      @(negedge clk);
      bus.i_lo_we = 1'b0;
      check("mtlo_idle", bus.o_lo, 32'h5555);

      issue(2'b00, 32'd3, 32'd5, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", bus.o_busy, 0);
      check("abort_done", bus.o_done, 0);
      check("abort_hi", bus.o_hi, 0);
      check("abort_lo", bus.o_lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(2'b00, 32'd3, 32'd5, 1'b1);
      wait_idle();

      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      n = 0;
      while (bus.o_busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, 33);
      check("done_pulse", bus.o_done, 1);
      @(negedge clk);
      check("done_width", bus.o_done, 0);

      issue(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b1);
      wait_idle();
      issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_idle();
      issue(2'b10, 32'd100, 32'd0, 1'b1);
      wait_idle();
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_idle();
      issue(2'b11, 32'h8000_0000, 32'h0, 1'b1);
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         issue(2'(i), $urandom, $urandom, 1'b1);
         wait_idle();
      end

      issue(2'b10, 32'd1000, 32'd7, 1'b1);
      repeat (3) @(negedge clk);
      lo0 = bus.o_lo;
      bus.i_start = 1'b1;
      bus.i_op    = 2'b00;
      bus.i_a     = 32'd5;
      bus.i_b     = 32'd5;
      bus.i_lo_we = 1'b1;
      bus.i_wdata = 32'h1234;
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_lo_we = 1'b0;
      check("mtlo_busy", bus.o_lo, lo0);
      wait_idle();
      repeat (3) @(negedge clk);
      check("sb_empty_ign", sb.size(), 0);

      bus.i_hi_we = 1'b1;
      bus.i_wdata = 32'h7777;
      issue(2'b00, 32'd2, 32'd2, 1'b1);
      bus.i_hi_we = 1'b0;
      check("mthi_with_start", bus.o_hi, 32'h7777);
      wait_idle();

      issue(2'b00, 32'd12, 32'd13, 1'b1);
      n = 0;
      while (!bus.o_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done", bus.o_done, 1);
      issue(2'b10, 32'd99, 32'd4, 1'b1);
      check("b2b_busy", bus.o_busy, 1);
      n = 1;
      while (!bus.o_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b2b_gap", n, 34);
      repeat (3) @(negedge clk);
      check("sb_empty_end", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
